// File: rtl/gemm_output_drain.sv
// GEMM output drain: snapshots the PE row accumulators, clears them,
// then streams shifted and saturated results to the result memory.
module gemm_output_drain #(
  parameter int NumPe      = 4,
  parameter int AccWidth   = 32,
  parameter int OutWidth   = 16,
  parameter int AddrWidth  = 16,
  parameter int ShiftWidth = $clog2(AccWidth)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumPe-1:0][AccWidth-1:0]     acc_i,
  input  logic                               capture_i,
  input  logic [AddrWidth-1:0]               base_addr_i,
  input  logic [ShiftWidth-1:0]              shift_i,
  output logic                               capture_ready_o,
  output logic                               acc_clr_o,
  output logic [OutWidth-1:0]                out_data_o,
  output logic [AddrWidth-1:0]               out_addr_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               done_o
);

  localparam int IdxWidth = (NumPe > 1) ? $clog2(NumPe) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumPe - 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [NumPe-1:0][AccWidth-1:0]   r_buf;
  logic [IdxWidth-1:0]              r_idx;
  logic [AddrWidth-1:0]             r_base;
  logic [ShiftWidth-1:0]            r_shift;
  logic                             r_clr;
  logic                             r_done;

  logic                             w_accept;
  logic                             w_xfer;
  logic                             w_last_xfer;
  logic                             w_valid;
  logic signed [AccWidth-1:0]       w_sel;
  logic signed [AccWidth-1:0]       w_shr;
  logic [AccWidth-OutWidth:0]       w_hi;
  logic                             w_ovf;
  logic [OutWidth-1:0]              w_sat;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_last_xfer = 1'b0;
    w_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = capture_i;
        if (capture_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_valid     = 1'b1;
        w_xfer      = out_ready_i;
        w_last_xfer = out_ready_i && (r_idx == LastIdx);
        if (w_last_xfer) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arithmetic shift rounds toward -inf; any upper bit differing
  // from the output sign bit means the value does not fit.
  always_comb begin
    w_sel = $signed(r_buf[r_idx]);
    w_shr = w_sel >>> r_shift;
    w_hi  = w_shr[AccWidth-1:OutWidth-1];
    w_ovf = !(&w_hi) && (|w_hi);
    if (w_ovf) begin
      w_sat = w_shr[AccWidth-1] ? {1'b1, {(OutWidth-1){1'b0}}}
                                : {1'b0, {(OutWidth-1){1'b1}}};
    end else begin
      w_sat = w_shr[OutWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_base  <= '0;
      r_shift <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clr   <= w_accept;
      r_done  <= w_last_xfer;
      if (w_accept) begin
        r_buf   <= acc_i;
        r_base  <= base_addr_i;
        r_shift <= shift_i;
        r_idx   <= '0;
      end else if (w_xfer) begin
        r_idx <= w_last_xfer ? '0 : r_idx + IdxWidth'(1);
      end
    end
  end

  assign capture_ready_o = (r_state == S_IDLE);
  assign acc_clr_o       = r_clr;
  assign done_o          = r_done;
  assign out_valid_o     = w_valid;
  assign out_data_o      = w_valid ? w_sat : '0;
  assign out_addr_o      = w_valid ? (r_base + AddrWidth'(r_idx)) : '0;

endmodule

// File: tb/tb_gemm_output_drain.sv
// Directed bench for gemm_output_drain: drain, saturation, stalls,
// busy capture, wrap, back-to-back snapshots and mid-drain reset.
module tb_gemm_output_drain;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [3:0][31:0]  acc_i;
  logic              capture_i;
  logic [15:0]       base_addr_i;
  logic [4:0]        shift_i;
  logic              capture_ready_o;
  logic              acc_clr_o;
  logic [15:0]       out_data_o;
  logic [15:0]       out_addr_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              done_o;

  int checks   = 0;
  int failures = 0;

  gemm_output_drain dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .acc_i           (acc_i),
    .capture_i       (capture_i),
    .base_addr_i     (base_addr_i),
    .shift_i         (shift_i),
    .capture_ready_o (capture_ready_o),
    .acc_clr_o       (acc_clr_o),
    .out_data_o      (out_data_o),
    .out_addr_o      (out_addr_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input string tag, input logic [3:0][31:0] a,
                      input logic [4:0] sh, input logic [15:0] b,
                      input logic [3:0][15:0] e);
    acc_i = a;
    shift_i = sh;
    base_addr_i = b;
    capture_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    capture_i = 1'b0;
    acc_i = ~a;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_clr"}, acc_clr_o, (k == 0));
      chk({tag, "_valid"}, out_valid_o, 1);
      chk({tag, "_crdy"}, capture_ready_o, 0);
      chk({tag, "_data"}, out_data_o, e[k]);
      chk({tag, "_addr"}, out_addr_o, 16'(b + 16'(k)));
      chk({tag, "_nodone"}, done_o, 0);
      tick();
    end
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_idle_valid"}, out_valid_o, 0);
    chk({tag, "_idle_crdy"}, capture_ready_o, 1);
    tick();
    chk({tag, "_done_end"}, done_o, 0);
  endtask

  initial begin
    logic [6:0] pat;
    logic [3:0][15:0] e;
    int n;

    rst_i = 1'b1;
    acc_i = '0;
    capture_i = 1'b0;
    base_addr_i = '0;
    shift_i = '0;
    out_ready_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_crdy", capture_ready_o, 1);
    chk("rst_clr", acc_clr_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_addr", out_addr_o, 0);

    snap("basic", {32'd0, 32'd3, -32'sd8, 32'd40}, 5'd2, 16'h0100,
         {16'd0, 16'd0, 16'hFFFE, 16'd10});

    snap("sat", {-32'sd32769, 32'd32767, 32'h8000_0000, 32'h7FFF_FFFF},
         5'd0, 16'h0000,
         {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF});

    // Stalls: 100,-100,7,-7 >>> 1 = 50,-50,3,-4
    e = {16'hFFFC, 16'd3, 16'hFFCE, 16'd50};
    pat = 7'b1101001;
    acc_i = {-32'sd7, 32'd7, -32'sd100, 32'd100};
    shift_i = 5'd1;
    base_addr_i = 16'h0020;
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready_i = pat[i];
      chk("bp_valid", out_valid_o, 1);
      chk("bp_data", out_data_o, e[n]);
      chk("bp_addr", out_addr_o, 16'h0020 + 16'(n));
      chk("bp_nodone", done_o, 0);
      if (pat[i]) n++;
      tick();
    end
    out_ready_i = 1'b1;
    chk("bp_done", done_o, 1);
    chk("bp_idle", out_valid_o, 0);
    tick();
    chk("bp_done_once", done_o, 0);

    // Busy capture ignored, address wraps past 0xFFFF
    acc_i = {32'd4, 32'd3, 32'd2, 32'd1};
    shift_i = 5'd0;
    base_addr_i = 16'hFFFE;
    capture_i = 1'b1;
    tick();
    chk("wrap_clr0", acc_clr_o, 1);
    base_addr_i = 16'h5555;
    acc_i = '1;
    for (int k = 0; k < 4; k++) begin
      capture_i = (k == 1 || k == 2);
      chk("wrap_data", out_data_o, 16'(k + 1));
      chk("wrap_addr", out_addr_o, 16'(16'hFFFE + 16'(k)));
      if (k > 0) chk("busy_noclr", acc_clr_o, 0);
      tick();
    end
    capture_i = 1'b0;
    chk("wrap_done", done_o, 1);
    chk("wrap_crdy", capture_ready_o, 1);
    tick();
    chk("busy_noclr_end", acc_clr_o, 0);
    chk("busy_idle", out_valid_o, 0);

    // Back-to-back: acc element k in cycle c is c*10+k
    shift_i = 5'd0;
    base_addr_i = 16'h0000;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        int pc;
        pc = c % 5;
        if (pc == 0) begin
          chk("b2b_done", done_o, 1);
          chk("b2b_crdy", capture_ready_o, 1);
          chk("b2b_novalid", out_valid_o, 0);
        end else begin
          chk("b2b_valid", out_valid_o, 1);
          chk("b2b_data", out_data_o, 16'((c - pc) * 10 + pc - 1));
          chk("b2b_addr", out_addr_o, 16'(pc - 1));
          chk("b2b_clr", acc_clr_o, (pc == 1));
        end
      end
      for (int k = 0; k < 4; k++) acc_i[k] = 32'(c * 10 + k);
      capture_i = 1'b1;
      tick();
    end
    capture_i = 1'b0;
    chk("b2b3_clr", acc_clr_o, 1);
    chk("b2b3_data0", out_data_o, 16'd100);
    tick();
    chk("b2b3_data1", out_data_o, 16'd101);
    tick();

    // Two transfers done; reset abandons the rest
    chk("mid_valid_pre", out_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_valid", out_valid_o, 0);
    chk("mid_crdy", capture_ready_o, 1);
    chk("mid_done", done_o, 0);
    chk("mid_clr", acc_clr_o, 0);
    tick();
    chk("mid_done2", done_o, 0);

    snap("after_rst", {32'd64, -32'sd1, -32'sd17, 32'd1000}, 5'd3,
         16'h0300, {16'd8, 16'hFFFF, 16'hFFFD, 16'd125});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
